// File: rtl/ps2_pkg.sv
// Shared PS/2 constants: host-transmit FSM encoding, line sync/filter geometry and us->cycle conversion.
// Used by the host transmitter and by the scancode receiver that shares the same pins.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_RTS,
    ST_WAIT_CLK,
    ST_WAIT_IDLE
  } tx_state_e;

  localparam int SYNC_STAGES = 2;
  localparam int HIST_LEN    = 4;
  // Oldest sample in the MSB: two highs followed by two lows.
  localparam logic [HIST_LEN-1:0] FALL_PATTERN = 4'b1100;

  function automatic longint unsigned us_to_cycles(input int unsigned us, input int unsigned clk_hz);
    return (longint'(us) * longint'(clk_hz)) / 64'd1_000_000;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command-byte handshake and frame status between a client (master) and the PS/2 host transmitter (slave).
// tx_valid/tx_ready accept one byte; done/err are single-cycle completion pulses.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       done;
  logic       err;

  modport master (output tx_data, tx_valid, input tx_ready, busy, done, err);
  modport slave  (input tx_data, tx_valid, output tx_ready, busy, done, err);
endinterface

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer plus 4-sample history for one PS/2 line; level is the newest filtered sample.
// Falling edge is flagged 4 cycles after the pin edge; no backpressure, runs every cycle.
module ps2_line_filter
  import ps2_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic line_i,
  output logic level_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [HIST_LEN-1:0]    hist_q, hist_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], line_i};
    hist_d = {hist_q[HIST_LEN-2:0], sync_q[SYNC_STAGES-1]};
  end

  // Idle bus level is high, so reset to all ones to avoid a spurious edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
      hist_q <= '1;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  assign level_o = hist_q[0];
  assign fall_o  = (hist_q == FALL_PATTERN);

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 11 device-clocked bits, ACK check; pins via open-drain enables.
// One byte accepted only in IDLE (no queue); data updates the cycle after a recognised falling edge; done/err pulse once.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_HZ           = 100_000_000,
  parameter int unsigned INHIBIT_US       = 100,
  parameter int unsigned START_TIMEOUT_US = 15000,
  parameter int unsigned FRAME_TIMEOUT_US = 2000
) (
  input  logic         clk,
  input  logic         rst,
  ps2_host_tx_if.slave tx,
  input  logic         ps2_clk_i,
  input  logic         ps2_data_i,
  output logic         ps2_clk_oe,
  output logic         ps2_data_oe
);

  localparam longint unsigned INHIBIT_CYC = us_to_cycles(INHIBIT_US, CLK_HZ);
  localparam longint unsigned START_CYC   = us_to_cycles(START_TIMEOUT_US, CLK_HZ);
  localparam longint unsigned FRAME_CYC   = us_to_cycles(FRAME_TIMEOUT_US, CLK_HZ);
  localparam longint unsigned MAX_A       = (START_CYC > FRAME_CYC) ? START_CYC : FRAME_CYC;
  localparam longint unsigned MAX_CYC     = (MAX_A > INHIBIT_CYC) ? MAX_A : INHIBIT_CYC;
  localparam int              TMR_W       = $clog2(MAX_CYC);

  localparam logic [TMR_W-1:0] INHIBIT_LAST = TMR_W'(INHIBIT_CYC - 1);
  localparam logic [TMR_W-1:0] START_LAST   = TMR_W'(START_CYC - 1);
  localparam logic [TMR_W-1:0] FRAME_LAST   = TMR_W'(FRAME_CYC - 1);

  tx_state_e        state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [3:0]       edge_q, edge_d;
  logic [8:0]       frame_q, frame_d;
  logic             data_oe_q, data_oe_d;
  logic             clk_lvl, clk_fall, data_lvl, data_fall_unused;
  logic             inhibit_last, done_o, err_o;

  ps2_line_filter u_clk_filt (
    .clk(clk), .rst(rst), .line_i(ps2_clk_i), .level_o(clk_lvl), .fall_o(clk_fall)
  );
  ps2_line_filter u_data_filt (
    .clk(clk), .rst(rst), .line_i(ps2_data_i), .level_o(data_lvl), .fall_o(data_fall_unused)
  );

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q + 1'b1;
    edge_d       = edge_q;
    frame_d      = frame_q;
    data_oe_d    = data_oe_q;
    inhibit_last = 1'b0;
    done_o       = 1'b0;
    err_o        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        timer_d   = '0;
        edge_d    = '0;
        data_oe_d = 1'b0;
        if (tx.tx_valid) begin
          frame_d = {~^tx.tx_data, tx.tx_data};
          state_d = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        // Start bit goes low during the final inhibit cycle, before the clock is released.
        if (timer_q == INHIBIT_LAST) begin
          inhibit_last = 1'b1;
          data_oe_d    = 1'b1;
          state_d      = ST_RTS;
        end
      end
      ST_RTS: begin
        timer_d = '0;
        state_d = ST_WAIT_CLK;
      end
      ST_WAIT_CLK: begin
        if (timer_q == ((edge_q == 4'd0) ? START_LAST : FRAME_LAST)) begin
          err_o = 1'b1;
        end else if (clk_fall) begin
          edge_d = edge_q + 4'd1;
          if (edge_q == 4'd0) timer_d = '0;
          if (edge_q <= 4'd8)      data_oe_d = ~frame_q[edge_q];
          else if (edge_q == 4'd9) data_oe_d = 1'b0;
          else if (data_lvl)       err_o     = 1'b1;
          else                     state_d   = ST_WAIT_IDLE;
        end
      end
      ST_WAIT_IDLE: begin
        if (clk_lvl && data_lvl)      done_o = 1'b1;
        else if (timer_q == FRAME_LAST) err_o = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    if (done_o || err_o) begin
      state_d   = ST_IDLE;
      data_oe_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      edge_q    <= '0;
      frame_q   <= '0;
      data_oe_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      edge_q    <= edge_d;
      frame_q   <= frame_d;
      data_oe_q <= data_oe_d;
    end
  end

  assign ps2_clk_oe  = (state_q == ST_INHIBIT);
  assign ps2_data_oe = inhibit_last | (data_oe_q & ~err_o);
  assign tx.tx_ready = (state_q == ST_IDLE);
  assign tx.busy     = (state_q != ST_IDLE);
  assign tx.done     = done_o;
  assign tx.err      = err_o;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed + randomized bench for ps2_host_tx with a 12.5 kHz open-drain device model on the shared lines.
// Runs at CLK_HZ = 1 MHz so one cycle is one microsecond and all timeouts stay short.
module tb_ps2_host_tx;

  localparam int unsigned CLK_HZ    = 1_000_000;
  localparam int          INH_CYC   = 100 * (CLK_HZ / 1_000_000);
  localparam int          START_CYC = 15000 * (CLK_HZ / 1_000_000);
  localparam int          HALF      = 40;  // 80 us device clock period

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic dev_clk_low  = 1'b0;
  logic dev_data_low = 1'b0;
  logic ps2_clk_i, ps2_data_i, ps2_clk_oe, ps2_data_oe;
  logic [9:0] dev_bits = '0;

  ps2_host_tx_if tx_if ();

  // Wired-AND open-drain bus with pull-ups.
  assign ps2_clk_i  = !(ps2_clk_oe || dev_clk_low);
  assign ps2_data_i = !(ps2_data_oe || dev_data_low);

  ps2_host_tx #(
    .CLK_HZ(CLK_HZ), .INHIBIT_US(100), .START_TIMEOUT_US(15000), .FRAME_TIMEOUT_US(2000)
  ) dut (
    .clk(clk), .rst(rst), .tx(tx_if),
    .ps2_clk_i(ps2_clk_i), .ps2_data_i(ps2_data_i),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  int err_cnt = 0;

  always @(negedge clk) begin
    if (!rst && tx_if.done) done_cnt++;
    if (!rst && tx_if.err)  err_cnt++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference frame: data LSB first, odd parity, stop bit high.
  function automatic logic [9:0] exp_frame(input logic [7:0] b);
    logic par;
    par = (($countones(b) % 2) == 0);
    return {1'b1, par, b};
  endfunction

  task automatic start_tx(input logic [7:0] b);
    int inh = 0;
    bit last_d = 0;
    @(negedge clk);
    chk("ready_in_idle", tx_if.tx_ready, 1);
    tx_if.tx_data  = b;
    tx_if.tx_valid = 1'b1;
    @(negedge clk);
    tx_if.tx_valid = 1'b0;
    tx_if.tx_data  = 8'($urandom);
    chk("clk_oe_after_accept", ps2_clk_oe, 1);
    chk("busy_after_accept", tx_if.busy, 1);
    while (ps2_clk_oe && inh < 4 * INH_CYC) begin
      last_d = ps2_data_oe;
      inh++;
      @(negedge clk);
    end
    chk("inhibit_cycles", inh, INH_CYC);
    chk("data_low_before_release", last_d, 1);
    chk("start_bit_after_release", ps2_data_oe, 1);
  endtask

  task automatic dev_run(input bit ack, input int abort_edge, output bit saw_rts);
    int t = 0;
    while (!(ps2_data_oe && !ps2_clk_oe) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    saw_rts = (t < 2000);
    if (!saw_rts) return;
    repeat (20) @(negedge clk);
    for (int k = 1; k <= 11; k++) begin
      if (k == 11) begin
        dev_data_low = ack;
        repeat (20) @(negedge clk);
      end
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      if (k == abort_edge) return;
      dev_clk_low = 1'b0;
      if (k <= 10) dev_bits[k-1] = ps2_data_i;
      repeat (HALF) @(negedge clk);
    end
    dev_data_low = 1'b0;
  endtask

  task automatic host_side(input logic [7:0] b, input bit ack, input bit spam);
    int t = 0;
    start_tx(b);
    while (!(tx_if.done || tx_if.err) && t < 4000) begin
      if (spam && t == 300) begin
        tx_if.tx_data  = 8'h55;
        tx_if.tx_valid = 1'b1;
      end
      if (spam && t == 305) chk("ready_low_while_busy", tx_if.tx_ready, 0);
      if (spam && t == 310) tx_if.tx_valid = 1'b0;
      @(negedge clk);
      t++;
    end
    chk("done_at_end", tx_if.done, ack);
    chk("err_at_end", tx_if.err, !ack);
    chk("lines_released_at_end", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    @(negedge clk);
    chk("ready_after_end", tx_if.tx_ready, 1);
  endtask

  task automatic run_frame(input logic [7:0] b, input bit ack, input bit spam);
    int d0 = done_cnt;
    int e0 = err_cnt;
    bit saw = 0;
    dev_bits = '0;
    fork
      host_side(b, ack, spam);
      dev_run(ack, 0, saw);
    join
    repeat (3) @(negedge clk);
    chk("device_saw_rts", saw, 1);
    chk("frame_bits", dev_bits, exp_frame(b));
    chk("done_pulses", done_cnt - d0, ack);
    chk("err_pulses", err_cnt - e0, !ack);
  endtask

  initial begin
    logic [7:0] b;
    int t;
    int d0, e0;
    bit saw;
    tx_if.tx_valid = 1'b0;
    tx_if.tx_data  = 8'h00;

    repeat (2) @(negedge clk);
    chk("rst_ready", tx_if.tx_ready, 1);
    chk("rst_busy", tx_if.busy, 0);
    chk("rst_clk_oe", ps2_clk_oe, 0);
    chk("rst_data_oe", ps2_data_oe, 0);
    chk("rst_done", tx_if.done, 0);
    chk("rst_err", tx_if.err, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    run_frame(8'hED, 1, 0);
    run_frame(8'hF4, 1, 0);
    run_frame(8'h00, 1, 0);
    for (int i = 0; i < 3; i++) run_frame(8'($urandom), 1, 0);

    // Missing ACK: data still high at edge 11.
    run_frame(8'($urandom), 0, 0);

    // Valid while busy with 0x55 must not replace the latched byte.
    b = 8'($urandom);
    if (b == 8'h55) b = 8'hAA;
    run_frame(b, 1, 1);

    // No device: clock never toggles after release.
    d0 = done_cnt;
    e0 = err_cnt;
    start_tx(8'($urandom));
    t = 0;
    while (!tx_if.err && t < START_CYC + 200) begin
      @(negedge clk);
      t++;
    end
    chk("nodev_err_delay", t, START_CYC);
    chk("nodev_lines_released", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    @(negedge clk);
    chk("nodev_ready", tx_if.tx_ready, 1);
    chk("nodev_err_pulses", err_cnt - e0, 1);
    chk("nodev_done_pulses", done_cnt - d0, 0);

    // Reset after edge 5; bit 4 is 0 so the host is pulling data low at that point.
    d0 = done_cnt;
    e0 = err_cnt;
    b = 8'($urandom) & 8'hEF;
    saw = 0;
    fork
      start_tx(b);
      dev_run(1, 5, saw);
    join
    chk("midrst_saw_rts", saw, 1);
    chk("midrst_data_oe_before", ps2_data_oe, 1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_clk_oe_async", ps2_clk_oe, 0);
    chk("midrst_data_oe_async", ps2_data_oe, 0);
    chk("midrst_ready_async", tx_if.tx_ready, 1);
    dev_clk_low = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_no_done", done_cnt - d0, 0);
    chk("midrst_no_err", err_cnt - e0, 0);
    run_frame(8'hFF, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
